pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. Combines the data-hazard flag from the hazard unit, ID-stage control-transfer decisions, exceptions and a multi-cycle multiply/divide unit. Produces per-stage write enables and flush strobes for PC, IF/ID, ID/EX and EX/MEM. Sits beside the hazard unit in the top level; all pipeline registers take their enables from this block only.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl_muldiv_timer.sv | 93 +++++++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types for the pipeline stall/flush sequencer:
//            ID-stage next-PC select encodings and the mult/div
//            sequencer state enum.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Next-PC select driven by the ID stage
  localparam logic [2:0] PC_SEQ    = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_J      = 3'b010;
  localparam logic [2:0] PC_JR     = 3'b011;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Groups the hazard/control inputs and the per-stage enable,
//            flush and mult/div status outputs of pipeline_ctrl.
// Ports    : none (signal bundle)
//            slave  modport - used by pipeline_ctrl
//            master modport - used by the surrounding datapath / bench
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if;

  logic        DataHazard;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic        Exception;
  logic        EX_MulDiv;
  logic        ID_MulDiv;
  logic        ID_ReadHiLo;

  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Flush;
  logic        MulDivStart;
  logic        MulDivBusy;
  logic        MulDivDone;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport slave (
    input  DataHazard, PCSrc, BranchTaken, Exception,
           EX_MulDiv, ID_MulDiv, ID_ReadHiLo,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           MulDivStart, MulDivBusy, MulDivDone, StallCount, FlushCount
  );

  modport master (
    output DataHazard, PCSrc, BranchTaken, Exception,
           EX_MulDiv, ID_MulDiv, ID_ReadHiLo,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           MulDivStart, MulDivBusy, MulDivDone, StallCount, FlushCount
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_muldiv_timer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_timer
// Purpose  : Tracks a multi-cycle mult/div operation. Starts when a mult/div
//            sits in EX while idle, stays busy for MULDIV_CYCLES cycles and
//            flags the last busy cycle. An exception aborts the operation.
// Ports    : clk        pipeline clock
//            reset      asynchronous active-low reset
//            exMulDiv   mult/div instruction in EX
//            exception  exception taken this cycle (abort / suppress start)
//            state      current sequencer state
//            start      one-cycle start pulse
//            busy       operation in progress
//            done       last busy cycle
// Revision : 1.0  initial release
// ============================================================================
module muldiv_timer
  import pipe_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exMulDiv,
  input  logic        exception,
  output ctrl_state_t state,
  output logic        start,
  output logic        busy,
  output logic        done
);

  localparam int             CNT_W    = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_start;
  logic             w_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_start     = 1'b0;
    w_done      = 1'b0;
    if (exception) begin
      // Abort any operation in flight; no Done is ever signalled for it.
      w_stateNext = RUN;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (exMulDiv) begin
            w_start     = 1'b1;
            w_stateNext = MD_BUSY;
            w_cntNext   = CNT_LOAD;
          end
        end
        MD_BUSY: begin
          if (r_cnt == '0) begin
            w_done      = 1'b1;
            w_stateNext = RUN;
          end else begin
            w_cntNext = r_cnt - 1'b1;
          end
        end
        default: begin
          w_stateNext = RUN;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  // Start is combinational from EX; hold it low while reset is asserted.
  assign state = r_state;
  assign start = reset & w_start;
  assign busy  = reset & (r_state == MD_BUSY);
  assign done  = reset & w_done;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central stall/flush sequencer for the five-stage MIPS pipeline.
//            Merges hazard-unit stalls, ID control transfers, exceptions and
//            mult/div occupancy into PC / IF-ID / ID-EX / EX-MEM enables and
//            flush strobes. Priority: exception > stall > taken > normal.
// Ports    : clk          pipeline clock
//            reset        asynchronous active-low reset
//            bus (slave)  DataHazard, PCSrc, BranchTaken, Exception,
//                         EX_MulDiv, ID_MulDiv, ID_ReadHiLo in;
//                         PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
//                         EX_MEM_Flush, MulDivStart/Busy/Done,
//                         StallCount, FlushCount out
// Config   : STALL_CNT_EN - when defined, saturating stall/flush counters
//            are built; otherwise StallCount/FlushCount read 0.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  ctrl_state_t w_state;
  logic        w_mdStart;
  logic        w_mdBusy;
  logic        w_mdDone;
  logic        w_mdStall;
  logic        w_stall;
  logic        w_taken;
  logic        w_pcWrite;
  logic        w_ifIdWrite;
  logic        w_ifIdFlush;
  logic        w_idExFlush;
  logic        w_exMemFlush;

  muldiv_timer #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_timer (
    .clk       (clk),
    .reset     (reset),
    .exMulDiv  (bus.EX_MulDiv),
    .exception (bus.Exception),
    .state     (w_state),
    .start     (w_mdStart),
    .busy      (w_mdBusy),
    .done      (w_mdDone)
  );

  // A HI/LO consumer or a second mult/div in ID must wait while the unit is
  // busy, and also in the start cycle itself (EX holds the producer).
  assign w_mdStall = (bus.ID_ReadHiLo | bus.ID_MulDiv)
                   & (w_mdBusy | ((w_state == RUN) & bus.EX_MulDiv));
  assign w_stall   = bus.DataHazard | w_mdStall;
  assign w_taken   = (bus.PCSrc == PC_J) | (bus.PCSrc == PC_JR)
                   | ((bus.PCSrc == PC_BRANCH) & bus.BranchTaken);

  always_comb begin
    w_pcWrite    = 1'b1;
    w_ifIdWrite  = 1'b1;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_exMemFlush = 1'b0;
    if (!reset) begin
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
    end else if (bus.Exception) begin
      w_ifIdFlush  = 1'b1;
      w_idExFlush  = 1'b1;
      w_exMemFlush = 1'b1;
    end else if (w_stall) begin
      // IF/ID is held, not flushed: a branch in ID re-evaluates next cycle.
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
      w_idExFlush = 1'b1;
    end else if (w_taken) begin
      w_ifIdFlush = 1'b1;
    end
  end

  assign bus.PC_Write     = w_pcWrite;
  assign bus.IF_ID_Write  = w_ifIdWrite;
  assign bus.IF_ID_Flush  = w_ifIdFlush;
  assign bus.ID_EX_Flush  = w_idExFlush;
  assign bus.EX_MEM_Flush = w_exMemFlush;
  assign bus.MulDivStart  = w_mdStart;
  assign bus.MulDivBusy   = w_mdBusy;
  assign bus.MulDivDone   = w_mdDone;

`ifdef STALL_CNT_EN
  logic [31:0] r_stallCount;
  logic [31:0] r_flushCount;
  logic        w_cntStall;
  logic        w_cntFlush;

  assign w_cntStall = w_stall & ~bus.Exception;
  assign w_cntFlush = w_taken & ~w_stall & ~bus.Exception;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_cntStall && (r_stallCount != 32'hFFFF_FFFF))
        r_stallCount <= r_stallCount + 32'd1;
      if (w_cntFlush && (r_flushCount != 32'hFFFF_FFFF))
        r_flushCount <= r_flushCount + 32'd1;
    end
  end

  assign bus.StallCount = r_stallCount;
  assign bus.FlushCount = r_flushCount;
`else
  assign bus.StallCount = 32'd0;
  assign bus.FlushCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed self-checking bench for pipeline_ctrl (MULDIV_CYCLES=4).
//            Control outputs are compared as the vector
//            {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;
  import pipe_pkg::*;

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [4:0] CTL_OFF   = 5'b00000;
  localparam logic [4:0] CTL_NORM  = 5'b11000;
  localparam logic [4:0] CTL_STALL = 5'b00010;
  localparam logic [4:0] CTL_TAKEN = 5'b11100;
  localparam logic [4:0] CTL_EXC   = 5'b11111;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] expStall;
  logic [31:0] expFlush;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .MULDIV_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] ctl = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush,
                    bus.ID_EX_Flush, bus.EX_MEM_Flush};

  task automatic idle();
    bus.DataHazard  = 1'b0;
    bus.PCSrc       = PC_SEQ;
    bus.BranchTaken = 1'b0;
    bus.Exception   = 1'b0;
    bus.EX_MulDiv   = 1'b0;
    bus.ID_MulDiv   = 1'b0;
    bus.ID_ReadHiLo = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    // Inputs that would normally act must be ignored under reset.
    bus.DataHazard = 1'b1;
    bus.PCSrc      = PC_J;
    bus.EX_MulDiv  = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_OFF) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_OFF);
    end
    checks++;
    if ({bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone} !== 3'b000) begin
      failures++; $display("FAIL reset_md got=%b exp=000",
                           {bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone});
    end
    checks++;
    if ({bus.StallCount, bus.FlushCount} !== 64'd0) begin
      failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", bus.StallCount, bus.FlushCount);
    end
    nextCycle();
    idle();
    reset = 1'b1;
    expStall = '0;
    expFlush = '0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_NORM) begin
      failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, CTL_NORM);
    end
    nextCycle();
  endtask

  task automatic test_data_hazard();
    bus.DataHazard = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_STALL) begin
      failures++; $display("FAIL hazard_stall got=%b exp=%b", ctl, CTL_STALL);
    end
    nextCycle();
    expStall = expStall + 1;
    bus.DataHazard = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_NORM) begin
      failures++; $display("FAIL hazard_after got=%b exp=%b", ctl, CTL_NORM);
    end
    checks++;
    if (bus.StallCount !== (CNT_EN ? expStall : 32'd0)) begin
      failures++; $display("FAIL hazard_stallcnt got=%0d exp=%0d", bus.StallCount,
                           CNT_EN ? expStall : 32'd0);
    end
    nextCycle();
  endtask

  task automatic test_branch();
    bus.PCSrc = PC_BRANCH; bus.BranchTaken = 1'b1; bus.DataHazard = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_STALL) begin
      failures++; $display("FAIL branch_stalled got=%b exp=%b", ctl, CTL_STALL);
    end
    nextCycle();
    expStall = expStall + 1;
    bus.DataHazard = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_TAKEN) begin
      failures++; $display("FAIL branch_taken got=%b exp=%b", ctl, CTL_TAKEN);
    end
    nextCycle();
    expFlush = expFlush + 1;
    idle();
    @(negedge clk);
    checks++;
    if (bus.FlushCount !== (CNT_EN ? expFlush : 32'd0)) begin
      failures++; $display("FAIL branch_flushcnt got=%0d exp=%0d", bus.FlushCount,
                           CNT_EN ? expFlush : 32'd0);
    end
    nextCycle();
    bus.PCSrc = PC_JR;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_TAKEN) begin
      failures++; $display("FAIL jr_taken got=%b exp=%b", ctl, CTL_TAKEN);
    end
    nextCycle();
    expFlush = expFlush + 1;
    bus.PCSrc = PC_BRANCH; bus.BranchTaken = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_NORM) begin
      failures++; $display("FAIL branch_not_taken got=%b exp=%b", ctl, CTL_NORM);
    end
    nextCycle();
    bus.PCSrc = PC_J;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_TAKEN) begin
      failures++; $display("FAIL j_taken got=%b exp=%b", ctl, CTL_TAKEN);
    end
    nextCycle();
    expFlush = expFlush + 1;
    idle();
    @(negedge clk);
    checks++;
    if (bus.FlushCount !== (CNT_EN ? expFlush : 32'd0)) begin
      failures++; $display("FAIL jump_flushcnt got=%0d exp=%0d", bus.FlushCount,
                           CNT_EN ? expFlush : 32'd0);
    end
    nextCycle();
  endtask

  task automatic test_muldiv();
    // Cycle t: mult in EX, HI/LO consumer in ID.
    bus.EX_MulDiv = 1'b1; bus.ID_ReadHiLo = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone, ctl} !== {3'b100, CTL_STALL}) begin
      failures++; $display("FAIL md_start got=%b exp=%b",
        {bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone, ctl}, {3'b100, CTL_STALL});
    end
    nextCycle();
    expStall = expStall + 1;
    bus.EX_MulDiv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone, ctl} !==
          {1'b0, 1'b1, (k == 4), CTL_STALL}) begin
        failures++; $display("FAIL md_busy_t+%0d got=%b exp=%b", k,
          {bus.MulDivStart, bus.MulDivBusy, bus.MulDivDone, ctl},
          {1'b0, 1'b1, (k == 4), CTL_STALL});
      end
      nextCycle();
      expStall = expStall + 1;
    end
    @(negedge clk);
    checks++;
    if ({bus.MulDivBusy, bus.MulDivDone, ctl} !== {2'b00, CTL_NORM}) begin
      failures++; $display("FAIL md_release got=%b exp=%b",
        {bus.MulDivBusy, bus.MulDivDone, ctl}, {2'b00, CTL_NORM});
    end
    checks++;
    if (bus.StallCount !== (CNT_EN ? expStall : 32'd0)) begin
      failures++; $display("FAIL md_stallcnt got=%0d exp=%0d", bus.StallCount,
                           CNT_EN ? expStall : 32'd0);
    end
    nextCycle();
    idle();
  endtask

  task automatic test_exception();
    bus.EX_MulDiv = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.MulDivStart, ctl} !== {1'b1, CTL_NORM}) begin
      failures++; $display("FAIL exc_start got=%b exp=%b", {bus.MulDivStart, ctl}, {1'b1, CTL_NORM});
    end
    nextCycle();
    bus.EX_MulDiv = 1'b0;
    nextCycle();
    bus.Exception = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.MulDivDone, ctl} !== {1'b0, CTL_EXC}) begin
      failures++; $display("FAIL exc_flush got=%b exp=%b", {bus.MulDivDone, ctl}, {1'b0, CTL_EXC});
    end
    nextCycle();
    bus.Exception = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.MulDivBusy, bus.MulDivDone} !== 2'b00) begin
        failures++; $display("FAIL exc_abort_t+%0d got=%b exp=00", k,
                             {bus.MulDivBusy, bus.MulDivDone});
      end
      nextCycle();
    end
    // Exception together with a mult/div in EX suppresses the start.
    bus.EX_MulDiv = 1'b1; bus.Exception = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.MulDivStart, ctl} !== {1'b0, CTL_EXC}) begin
      failures++; $display("FAIL exc_nostart got=%b exp=%b", {bus.MulDivStart, ctl}, {1'b0, CTL_EXC});
    end
    nextCycle();
    idle();
    @(negedge clk);
    checks++;
    if (bus.MulDivBusy !== 1'b0) begin
      failures++; $display("FAIL exc_nostart_busy got=%b exp=0", bus.MulDivBusy);
    end
    nextCycle();
  endtask

  task automatic test_reset_mid();
    bus.EX_MulDiv = 1'b1;
    nextCycle();
    bus.EX_MulDiv = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.MulDivBusy !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy got=%b exp=1", bus.MulDivBusy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.MulDivBusy, ctl} !== {1'b0, CTL_OFF}) begin
      failures++; $display("FAIL rstmid_low got=%b exp=%b", {bus.MulDivBusy, ctl}, {1'b0, CTL_OFF});
    end
    nextCycle();
    reset = 1'b1;
    expStall = '0;
    expFlush = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.MulDivBusy, bus.MulDivDone, ctl} !== {2'b00, CTL_NORM}) begin
        failures++; $display("FAIL rstmid_after%0d got=%b exp=%b", k,
          {bus.MulDivBusy, bus.MulDivDone, ctl}, {2'b00, CTL_NORM});
      end
      nextCycle();
    end
    @(negedge clk);
    checks++;
    if (bus.StallCount !== 32'd0) begin
      failures++; $display("FAIL rstmid_stallcnt got=%0d exp=0", bus.StallCount);
    end
    nextCycle();
  endtask

`ifdef STALL_CNT_EN
  task automatic test_saturation();
    bus.DataHazard = 1'b1;
    @(negedge clk);
    force dut.r_stallCount = 32'hFFFF_FFFD;
    #1;
    release dut.r_stallCount;
    for (int k = 0; k < 5; k++) nextCycle();
    @(negedge clk);
    checks++;
    if (bus.StallCount !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL stall_saturate got=%h exp=ffffffff", bus.StallCount);
    end
    nextCycle();
    idle();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    expStall = '0;
    expFlush = '0;
    reset    = 1'b0;
    idle();
    test_reset();
    test_data_hazard();
    test_branch();
    test_muldiv();
    test_exception();
    test_reset_mid();
`ifdef STALL_CNT_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
